// File: rtl/gpio_pkg.sv
// Shared register map, window geometry and write-mask helper for the GPIO bank.
package gpio_pkg;

  localparam int          GPIO_DATA_W    = 32;
  localparam int          GPIO_DEF_WIDTH = 4;
  localparam logic [31:0] GPIO_WIN_SIZE  = 32'h0000_0040;

  // Word index within the window, i.e. bus_addr[5:2].
  typedef enum logic [3:0] {
    GPIO_OUT  = 4'h0,
    GPIO_SET  = 4'h1,
    GPIO_CLR  = 4'h2,
    GPIO_TGL  = 4'h3,
    GPIO_DIR  = 4'h4,
    GPIO_IN   = 4'h5,
    GPIO_IEN  = 4'h6,
    GPIO_STAT = 4'h7,
    GPIO_EDGE = 4'h8
  } gpio_reg_e;

  function automatic logic [GPIO_DATA_W-1:0] gpio_byte_mask(input logic [3:0] wen);
    gpio_byte_mask = {{8{wen[3]}}, {8{wen[2]}}, {8{wen[1]}}, {8{wen[0]}}};
  endfunction

endpackage

// File: rtl/gpio_bank_if.sv
// CPU data-bus port of the GPIO bank: address, write data, byte enables and the read return.
interface gpio_bank_if;

  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wen;
  logic [31:0] bus_rdata;
  logic        bus_sel;

  modport master (
    output bus_addr,
    output bus_wdata,
    output bus_wen,
    input  bus_rdata,
    input  bus_sel
  );

  modport slave (
    input  bus_addr,
    input  bus_wdata,
    input  bus_wen,
    output bus_rdata,
    output bus_sel
  );

endinterface

// File: rtl/gpio_sync.sv
// Multi-stage flop synchroniser for the asynchronous pad inputs.
module gpio_sync #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_chain [STAGES];

  // Shift pad values down the chain once per clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        r_chain[i] <= '0;
      end
    end else begin
      r_chain[0] <= i_d;
      for (int i = 1; i < STAGES; i++) begin
        r_chain[i] <= r_chain[i-1];
      end
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/gpio_bank.sv
// Memory-mapped GPIO bank: OUT/DIR registers with atomic set/clear/toggle,
// synchronised inputs and per-bit edge-capture interrupts.
module gpio_bank
  import gpio_pkg::*;
#(
  parameter int               WIDTH       = GPIO_DEF_WIDTH,
  parameter logic [31:0]      BASE        = 32'h2000_0000,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] RESET_OUT   = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  gpio_bank_if.slave       bus,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  localparam int                WARM_W    = $clog2(SYNC_STAGES + 2);
  localparam logic [WARM_W-1:0] WARM_INIT = WARM_W'(SYNC_STAGES + 1);

  logic [WIDTH-1:0]  r_out;
  logic [WIDTH-1:0]  r_dir;
  logic [WIDTH-1:0]  r_ien;
  logic [WIDTH-1:0]  r_stat;
  logic [WIDTH-1:0]  r_edge;
  logic [WIDTH-1:0]  r_prev;
  logic [WARM_W-1:0] r_warm;
  logic              r_irq;

  logic             w_sel;
  logic             w_we;
  gpio_reg_e        w_reg;
  logic [31:0]      w_bmask;
  logic [WIDTH-1:0] w_mask;
  logic [WIDTH-1:0] w_wd;
  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_cap;
  logic [WIDTH-1:0] w_w1c;
  logic [WIDTH-1:0] w_out_nxt;
  logic [WIDTH-1:0] w_dir_nxt;
  logic [WIDTH-1:0] w_ien_nxt;
  logic [WIDTH-1:0] w_edge_nxt;
  logic [WIDTH-1:0] w_stat_nxt;
  logic [31:0]      w_rdata;
  logic             w_unused;

  gpio_sync #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (gpio_in),
    .o_q   (w_sync)
  );

  // BASE is 64-byte aligned, so the window match is a compare of the upper address bits.
  assign w_sel   = (bus.bus_addr[31:6] == BASE[31:6]);
  assign w_we    = w_sel & (|bus.bus_wen);
  assign w_reg   = gpio_reg_e'(bus.bus_addr[5:2]);
  assign w_bmask = gpio_byte_mask(bus.bus_wen);
  assign w_mask  = w_bmask[WIDTH-1:0];
  assign w_wd    = bus.bus_wdata[WIDTH-1:0] & w_mask;

  assign w_rise = w_sync & ~r_prev;
  assign w_fall = ~w_sync & r_prev;
  assign w_cap  = (r_warm == '0) ? ((r_edge & w_rise) | (~r_edge & w_fall)) : '0;

  // Register next-state from the bus write; a fresh capture overrides a W1C on the same bit.
  always_comb begin
    w_out_nxt  = r_out;
    w_dir_nxt  = r_dir;
    w_ien_nxt  = r_ien;
    w_edge_nxt = r_edge;
    w_w1c      = '0;
    if (w_we) begin
      case (w_reg)
        GPIO_OUT:  w_out_nxt  = (r_out & ~w_mask) | w_wd;
        GPIO_SET:  w_out_nxt  = r_out | w_wd;
        GPIO_CLR:  w_out_nxt  = r_out & ~w_wd;
        GPIO_TGL:  w_out_nxt  = r_out ^ w_wd;
        GPIO_DIR:  w_dir_nxt  = (r_dir & ~w_mask) | w_wd;
        GPIO_IEN:  w_ien_nxt  = (r_ien & ~w_mask) | w_wd;
        GPIO_STAT: w_w1c      = w_wd;
        GPIO_EDGE: w_edge_nxt = (r_edge & ~w_mask) | w_wd;
        default:   w_w1c      = '0;
      endcase
    end else begin
      w_w1c = '0;
    end
    w_stat_nxt = (r_stat & ~w_w1c) | w_cap;
  end

  // State update; irq is registered from the same next values so it moves with STAT/IRQ_EN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out  <= RESET_OUT;
      r_dir  <= '0;
      r_ien  <= '0;
      r_stat <= '0;
      r_edge <= '0;
      r_prev <= '0;
      r_warm <= WARM_INIT;
      r_irq  <= 1'b0;
    end else begin
      r_out  <= w_out_nxt;
      r_dir  <= w_dir_nxt;
      r_ien  <= w_ien_nxt;
      r_stat <= w_stat_nxt;
      r_edge <= w_edge_nxt;
      r_prev <= w_sync;
      r_irq  <= |(w_stat_nxt & w_ien_nxt);
      if (r_warm != '0) begin
        r_warm <= r_warm - WARM_W'(1);
      end else begin
        r_warm <= r_warm;
      end
    end
  end

  // Combinational read return, zero outside the window and for reserved words.
  always_comb begin
    w_rdata = 32'h0000_0000;
    if (w_sel) begin
      case (w_reg)
        GPIO_OUT, GPIO_SET, GPIO_CLR, GPIO_TGL: w_rdata = 32'(r_out);
        GPIO_DIR:  w_rdata = 32'(r_dir);
        GPIO_IN:   w_rdata = 32'(w_sync);
        GPIO_IEN:  w_rdata = 32'(r_ien);
        GPIO_STAT: w_rdata = 32'(r_stat);
        GPIO_EDGE: w_rdata = 32'(r_edge);
        default:   w_rdata = 32'h0000_0000;
      endcase
    end else begin
      w_rdata = 32'h0000_0000;
    end
  end

  assign bus.bus_rdata = w_rdata;
  assign bus.bus_sel   = w_sel;
  assign gpio_out      = r_out;
  assign gpio_oe       = r_dir;
  assign irq           = r_irq;

  // Byte-lane and sub-word address bits that narrow configurations never look at.
  assign w_unused = ^{bus.bus_addr[1:0], bus.bus_wdata, w_bmask};

endmodule

// File: tb/tb_gpio_bank.sv
// Directed bench for gpio_bank: stimulus queues expectations, a negedge monitor compares them.
module tb_gpio_bank;

  localparam logic [31:0] BASE = 32'h2000_0000;

  localparam int K_RD_A  = 0;
  localparam int K_OUT_A = 1;
  localparam int K_OE_A  = 2;
  localparam int K_IRQ_A = 3;
  localparam int K_SEL_A = 4;
  localparam int K_OUT_B = 5;
  localparam int K_RD_B  = 6;

  typedef struct {
    int          due;
    int          kind;
    logic [31:0] exp;
    int          tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  gin_a, gout_a, goe_a;
  logic        irq_a;
  logic [31:0] gin_b, gout_b, goe_b;
  logic        irq_b;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   tag_n = 0;

  gpio_bank_if bus_a();
  gpio_bank_if bus_b();

  gpio_bank #(.WIDTH(4), .BASE(BASE), .SYNC_STAGES(2), .RESET_OUT(4'hA)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a), .gpio_in(gin_a),
    .gpio_out(gout_a), .gpio_oe(goe_a), .irq(irq_a)
  );

  gpio_bank #(.WIDTH(32), .BASE(BASE), .SYNC_STAGES(2), .RESET_OUT(32'h0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b), .gpio_in(gin_b),
    .gpio_out(gout_b), .gpio_oe(goe_b), .irq(irq_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] observe(input int kind);
    case (kind)
      K_RD_A:  return bus_a.bus_rdata;
      K_OUT_A: return 32'(gout_a);
      K_OE_A:  return 32'(goe_a);
      K_IRQ_A: return 32'(irq_a);
      K_SEL_A: return 32'(bus_a.bus_sel);
      K_OUT_B: return gout_b;
      K_RD_B:  return bus_b.bus_rdata;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic string kname(input int kind);
    case (kind)
      K_RD_A:  return "rdata_a";
      K_OUT_A: return "gpio_out_a";
      K_OE_A:  return "gpio_oe_a";
      K_IRQ_A: return "irq_a";
      K_SEL_A: return "bus_sel_a";
      K_OUT_B: return "gpio_out_b";
      K_RD_B:  return "rdata_b";
      default: return "unknown";
    endcase
  endfunction

  // Monitor: pop every expectation due by this cycle and compare against the live outputs.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      act = observe(e.kind);
      checks++;
      if (act !== e.exp) begin
        failures++;
        $display("FAIL %s#%0d actual=%h required=%h", kname(e.kind), e.tag, act, e.exp);
      end
    end
  end

  task automatic expect_now(input int kind, input logic [31:0] exp);
    q.push_back('{due: cyc, kind: kind, exp: exp, tag: tag_n});
    tag_n++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_a(input logic [31:0] off, input logic [31:0] d, input logic [3:0] wen);
    bus_a.bus_addr  = BASE + off;
    bus_a.bus_wdata = d;
    bus_a.bus_wen   = wen;
    step();
    bus_a.bus_wen   = 4'h0;
  endtask

  task automatic rd_a(input logic [31:0] off, input logic [31:0] exp, input logic exp_sel);
    bus_a.bus_addr = BASE + off;
    bus_a.bus_wen  = 4'h0;
    expect_now(K_RD_A, exp);
    expect_now(K_SEL_A, 32'(exp_sel));
    step();
  endtask

  task automatic wr_b(input logic [31:0] off, input logic [31:0] d, input logic [3:0] wen);
    bus_b.bus_addr  = BASE + off;
    bus_b.bus_wdata = d;
    bus_b.bus_wen   = wen;
    step();
    bus_b.bus_wen   = 4'h0;
  endtask

  initial begin
    int guard;
    bus_a.bus_addr = 32'h0; bus_a.bus_wdata = 32'h0; bus_a.bus_wen = 4'h0;
    bus_b.bus_addr = 32'h0; bus_b.bus_wdata = 32'h0; bus_b.bus_wen = 4'h0;
    gin_a = 4'h0;
    gin_b = 32'h0;
    repeat (3) step();
    rst_n = 1'b1;

    // Reset state, reserved word and out-of-window access.
    expect_now(K_OUT_A, 32'hA);
    expect_now(K_OE_A, 32'h0);
    expect_now(K_IRQ_A, 32'h0);
    rd_a(32'h00, 32'h0000_000A, 1'b1);
    rd_a(32'h24, 32'h0, 1'b1);
    rd_a(32'h40, 32'h0, 1'b0);

    // Plain, set, clear and toggle writes; a write with no byte enables is a no-op.
    wr_a(32'h00, 32'h5, 4'hF); expect_now(K_OUT_A, 32'h5);
    wr_a(32'h04, 32'h8, 4'hF); expect_now(K_OUT_A, 32'hD);
    wr_a(32'h08, 32'h1, 4'hF); expect_now(K_OUT_A, 32'hC);
    wr_a(32'h0C, 32'h3, 4'hF); expect_now(K_OUT_A, 32'hF);
    wr_a(32'h00, 32'h0, 4'h0); expect_now(K_OUT_A, 32'hF);
    wr_a(32'h00, 32'h0, 4'hE); expect_now(K_OUT_A, 32'hF);
    rd_a(32'h04, 32'hF, 1'b1);
    rd_a(32'h0C, 32'hF, 1'b1);

    // Direction, misaligned read, reserved write.
    wr_a(32'h10, 32'h6, 4'h1); expect_now(K_OE_A, 32'h6);
    rd_a(32'h11, 32'h6, 1'b1);
    wr_a(32'h24, 32'hFFFF_FFFF, 4'hF);
    rd_a(32'h24, 32'h0, 1'b1);

    // Wide instance byte enables.
    wr_b(32'h00, 32'hFFFF_FFFF, 4'b0100); expect_now(K_OUT_B, 32'h00FF_0000);
    wr_b(32'h0C, 32'hFFFF_FFFF, 4'b1001); expect_now(K_OUT_B, 32'hFFFF_00FF);
    bus_b.bus_addr = BASE; expect_now(K_RD_B, 32'hFFFF_00FF); step();

    // Rising-edge interrupt latency: IN at t+2, STAT and irq at t+3.
    wr_a(32'h18, 32'h1, 4'hF);
    wr_a(32'h20, 32'h1, 4'hF);
    gin_a = 4'h1;
    expect_now(K_IRQ_A, 32'h0);
    rd_a(32'h14, 32'h0, 1'b1);
    rd_a(32'h14, 32'h0, 1'b1);
    expect_now(K_IRQ_A, 32'h0);
    rd_a(32'h14, 32'h1, 1'b1);
    expect_now(K_IRQ_A, 32'h1);
    rd_a(32'h1C, 32'h1, 1'b1);

    // Falling edge is ignored with IRQ_EDGE=1; W1C clears.
    gin_a = 4'h0;
    repeat (5) step();
    expect_now(K_IRQ_A, 32'h1);
    rd_a(32'h1C, 32'h1, 1'b1);
    wr_a(32'h1C, 32'h1, 4'h1);
    expect_now(K_IRQ_A, 32'h0);
    rd_a(32'h1C, 32'h0, 1'b1);

    // Capture and W1C in the same cycle: capture wins.
    gin_a = 4'h1;
    step();
    step();
    wr_a(32'h1C, 32'h1, 4'hF);
    rd_a(32'h1C, 32'h1, 1'b1);
    wr_a(32'h1C, 32'h1, 4'hF);
    rd_a(32'h1C, 32'h0, 1'b1);

    // Reset during a write, pads high through reset, rising capture armed during warm-up.
    gin_a = 4'hF;
    bus_a.bus_addr = BASE; bus_a.bus_wdata = 32'h3; bus_a.bus_wen = 4'hF;
    rst_n = 1'b0;
    step();
    bus_a.bus_wen = 4'h0;
    step();
    rst_n = 1'b1;
    wr_a(32'h20, 32'hF, 4'hF);
    expect_now(K_OUT_A, 32'hA);
    repeat (6) step();
    expect_now(K_IRQ_A, 32'h0);
    rd_a(32'h1C, 32'h0, 1'b1);

    // Falling-edge pulse on bit 2 only.
    wr_a(32'h20, 32'h0, 4'hF);
    wr_a(32'h18, 32'h4, 4'hF);
    gin_a = 4'hB;
    repeat (4) step();
    expect_now(K_IRQ_A, 32'h1);
    rd_a(32'h1C, 32'h4, 1'b1);
    gin_a = 4'hF;
    repeat (4) step();
    rd_a(32'h1C, 32'h4, 1'b1);

    guard = 0;
    while (q.size() > 0 && guard < 100) begin
      step();
      guard++;
    end
    if (q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
